multi_dice_roller: RTL and testbench

Parametrised successor of the single-die roller. Rolls NUM_DICE dice with a runtime-selectable side count (2..8), drives one 7-segment display plus decimal point per die, and lets individual dice be held across rolls. It keeps the free-running 16-bit LFSR and the slowing "tumble" animation, and adds a running sum, a busy flag and a completion pulse for downstream scoring logic.

---
 rtl/dice_pkg.sv | 33 +++
 rtl/multi_dice_roller_if.sv | 31 +++
 rtl/dice_seg7.sv | 20 ++
 rtl/multi_dice_roller.sv | 138 +++++++++++++
 tb/tb_multi_dice_roller.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/dice_pkg.sv
// Shared types and constants for the multi-die roller: FSM states, LFSR seed/taps,
// the 7-segment table and the side-count clamp.
package dice_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        ROLLING = 1'b1
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'h00DA;
    // Galois taps for x^16+x^14+x^13+x^11+1 applied after the right shift.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Entry k holds segments gfedcba for die value k+1.
    localparam logic [6:0] SEG_LUT [8] = '{
        7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111100, 7'b0000111, 7'b1111111
    };

    function automatic logic [3:0] clamp_sides(input logic [3:0] sides);
        if (sides < 4'd2) begin
            return 4'd2;
        end else if (sides > 4'd8) begin
            return 4'd8;
        end
        return sides;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] lfsr);
        return {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/multi_dice_roller_if.sv
// Bus between the dice roller and its user: roll request, per-die display, sum and status.
interface multi_dice_roller_if
    import dice_pkg::*;
#(
    parameter int NUM_DICE = 2
);
    localparam int SUM_W = $clog2(8 * NUM_DICE + 1);

    // ROLL is a level request with no ready: every cycle it is high the roller accepts
    // SIDES/HOLD and (re)starts. BUSY/DONE report progress; DONE is a one-cycle pulse.
    logic                    ROLL;
    logic [3:0]              SIDES;
    logic [NUM_DICE-1:0]     HOLD;
    logic [8*NUM_DICE-1:0]   LEDS;
    logic [SUM_W-1:0]        SUM;
    logic                    BUSY;
    logic                    DONE;
    state_t                  DBG_STATE;
    logic [15:0]             DBG_LFSR;

    modport master (
        output ROLL, SIDES, HOLD,
        input  LEDS, SUM, BUSY, DONE, DBG_STATE, DBG_LFSR
    );

    modport slave (
        input  ROLL, SIDES, HOLD,
        output LEDS, SUM, BUSY, DONE, DBG_STATE, DBG_LFSR
    );

endinterface

// File: rtl/dice_seg7.sv
// Die value (1..8) to 7-segment pattern gfedcba; out-of-range values blank the digit.
module dice_seg7
    import dice_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [6:0] o_seg
);

    logic [3:0] w_idx;

    assign w_idx = i_val - 4'd1;

    always_comb begin
        o_seg = 7'b0000000;
        if (i_val >= 4'd1 && i_val <= 4'd8) begin
            o_seg = SEG_LUT[w_idx[2:0]];
        end
    end

endmodule

// File: rtl/multi_dice_roller.sv
// NUM_DICE dice driven by a free-running LFSR with a slowing tumble animation,
// per-die hold, registered 7-segment outputs, running sum and completion pulse.
module multi_dice_roller
    import dice_pkg::*;
#(
    parameter int NUM_DICE  = 2,
    parameter int DIV_START = 2,
    parameter int DIV_END   = 160
) (
    input  logic                CLK,
    input  logic                RST,
    multi_dice_roller_if.slave  bus
);

    localparam int SUM_W = $clog2(8 * NUM_DICE + 1);
    localparam logic [7:0] DIV_START_C = 8'(DIV_START);
    localparam logic [7:0] DIV_END_C   = 8'(DIV_END);

    state_t              r_state;
    logic [15:0]         r_lfsr;
    logic [7:0]          r_counter;
    logic [7:0]          r_clkdiv;
    logic [3:0]          r_sides;
    logic [NUM_DICE-1:0] r_hold;
    logic [3:0]          r_val [NUM_DICE];
    logic [6:0]          r_seg [NUM_DICE];
    logic                r_dp;
    logic                r_busy;
    logic                r_done;
    logic [SUM_W-1:0]    r_sum;

    logic [3:0]          w_rand_val [NUM_DICE];
    logic [6:0]          w_rand_seg [NUM_DICE];
    logic [3:0]          w_next_val [NUM_DICE];
    logic [SUM_W-1:0]    w_next_sum;
    logic [7:0]          w_count_inc;
    logic                w_tick;
    logic                w_last;

    assign w_count_inc = r_counter + 8'd1;
    assign w_tick      = (r_state == ROLLING) && (w_count_inc == r_clkdiv);
    assign w_last      = (r_clkdiv + 8'd1) == DIV_END_C;

    // Each die draws 3 LFSR bits; the segment pattern is decoded before the register
    // so LEDS comes straight from flops.
    for (genvar gi = 0; gi < NUM_DICE; gi++) begin : g_die
        logic [2:0] w_r;
        assign w_r            = r_lfsr[3*gi +: 3];
        assign w_rand_val[gi] = ({1'b0, w_r} % r_sides) + 4'd1;
        assign w_next_val[gi] = r_hold[gi] ? r_val[gi] : w_rand_val[gi];

        dice_seg7 u_seg (
            .i_val (w_rand_val[gi]),
            .o_seg (w_rand_seg[gi])
        );

        assign bus.LEDS[8*gi +: 8] = {r_dp, r_seg[gi]};
    end

    always_comb begin
        w_next_sum = '0;
        for (int i = 0; i < NUM_DICE; i++) begin
            w_next_sum = w_next_sum + SUM_W'(w_next_val[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_counter <= 8'd0;
            r_clkdiv  <= DIV_END_C;
            r_sides   <= 4'd2;
            r_hold    <= '0;
            for (int i = 0; i < NUM_DICE; i++) begin
                r_val[i] <= 4'd1;
                r_seg[i] <= SEG_LUT[0];
            end
            r_dp      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sum     <= SUM_W'(NUM_DICE);
        end else begin
            r_done <= 1'b0;
            // A roll request wins over everything, including the final update edge.
            if (bus.ROLL) begin
                r_sides   <= clamp_sides(bus.SIDES);
                r_hold    <= bus.HOLD;
                r_counter <= 8'd0;
                r_clkdiv  <= DIV_START_C;
                r_dp      <= 1'b0;
                r_busy    <= 1'b1;
                r_state   <= ROLLING;
            end else begin
                case (r_state)
                    ROLLING: begin
                        if (w_tick) begin
                            r_counter <= 8'd0;
                            r_clkdiv  <= r_clkdiv + 8'd1;
                            for (int i = 0; i < NUM_DICE; i++) begin
                                if (!r_hold[i]) begin
                                    r_val[i] <= w_rand_val[i];
                                    r_seg[i] <= w_rand_seg[i];
                                end
                            end
                            r_sum <= w_next_sum;
                            if (w_last) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_dp    <= 1'b1;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_counter <= w_count_inc;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.SUM       = r_sum;
    assign bus.BUSY      = r_busy;
    assign bus.DONE      = r_done;
    assign bus.DBG_STATE = r_state;
    assign bus.DBG_LFSR  = r_lfsr;

endmodule

// File: tb/tb_multi_dice_roller.sv
// Directed bench for multi_dice_roller with NUM_DICE=2, DIV_START=2, DIV_END=5.
module tb_multi_dice_roller;
    import dice_pkg::*;

    logic clk;
    logic rst;

    multi_dice_roller_if #(.NUM_DICE(2)) bus ();

    multi_dice_roller #(
        .NUM_DICE  (2),
        .DIV_START (2),
        .DIV_END   (5)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [15:0] exp_q [$];
    int          exp_val [2];
    logic [15:0] m_lfsr;

    function automatic logic [15:0] model_step(input logic [15:0] l);
        return {l[0], l[15], l[14] ^ l[0], l[13] ^ l[0], l[12], l[11] ^ l[0], l[10:1]};
    endfunction

    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'h00DA;
        else     m_lfsr <= model_step(m_lfsr);
    end

    function automatic int bclamp(input int s);
        if (s < 2) return 2;
        if (s > 8) return 8;
        return s;
    endfunction

    function automatic logic [6:0] v2s(input int v);
        case (v)
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111100;
            7: return 7'b0000111;
            8: return 7'b1111111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int s2v(input logic [6:0] s);
        case (s)
            7'b0000110: return 1;
            7'b1011011: return 2;
            7'b1001111: return 3;
            7'b1100110: return 4;
            7'b1101101: return 5;
            7'b1111100: return 6;
            7'b0000111: return 7;
            7'b1111111: return 8;
            default:    return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: called at a negedge; the next posedge is edge 0 of the roll
    task automatic run_roll(input logic [3:0] sides, input logic [1:0] hold,
                            input int restart_at, input int done_edge,
                            input logic [31:0] upd_mask, input string tag);
        logic [15:0] exp_leds;
        logic        dp;
        bus.ROLL  = 1'b1;
        bus.SIDES = sides;
        bus.HOLD  = hold;
        @(negedge clk);
        bus.ROLL = 1'b0;
        chk({tag, "_busy_e0"}, 32'(bus.BUSY), 32'd1);
        chk({tag, "_dp_e0"}, {30'd0, bus.LEDS[15], bus.LEDS[7]}, 32'd0);
        chk({tag, "_state_e0"}, 32'(bus.DBG_STATE), 32'(ROLLING));
        for (int e = 1; e <= done_edge + 2; e++) begin
            if (e == restart_at) bus.ROLL = 1'b1;
            if (upd_mask[e]) begin
                for (int i = 0; i < 2; i++) begin
                    if (!hold[i]) exp_val[i] = (int'(m_lfsr[3*i +: 3]) % bclamp(int'(sides))) + 1;
                end
            end
            dp = (e >= done_edge);
            exp_q.push_back({dp, v2s(exp_val[1]), dp, v2s(exp_val[0])});
            @(negedge clk);
            bus.ROLL = 1'b0;
            exp_leds = exp_q.pop_front();
            chk($sformatf("%s_leds_e%0d", tag, e), 32'(bus.LEDS), 32'(exp_leds));
            chk($sformatf("%s_sum_e%0d", tag, e), 32'(bus.SUM), 32'(exp_val[0] + exp_val[1]));
            chk($sformatf("%s_busy_e%0d", tag, e), 32'(bus.BUSY), 32'(e < done_edge));
            chk($sformatf("%s_done_e%0d", tag, e), 32'(bus.DONE), 32'(e == done_edge));
        end
    endtask

    task automatic range_rolls(input logic [3:0] sides, input int max_v, input string tag);
        int v0, v1, waited;
        for (int r = 0; r < 200; r++) begin
            bus.ROLL  = 1'b1;
            bus.SIDES = sides;
            bus.HOLD  = 2'b00;
            @(negedge clk);
            bus.ROLL = 1'b0;
            waited = 0;
            while (bus.DONE !== 1'b1 && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            chk({tag, "_done"}, 32'(bus.DONE), 32'd1);
            v0 = s2v(bus.LEDS[6:0]);
            v1 = s2v(bus.LEDS[14:8]);
            chk({tag, "_die0"}, 32'(v0 >= 1 && v0 <= max_v), 32'd1);
            chk({tag, "_die1"}, 32'(v1 >= 1 && v1 <= max_v), 32'd1);
            chk({tag, "_sum"}, 32'(bus.SUM), 32'(v0 + v1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        logic done_seen;
        rst       = 1'b1;
        bus.ROLL  = 1'b0;
        bus.SIDES = 4'd6;
        bus.HOLD  = 2'b00;
        repeat (3) @(negedge clk);

        // reset state, first cycle after RST falls
        rst = 1'b0;
        chk("rst_leds", 32'(bus.LEDS), 32'h8686);
        chk("rst_sum", 32'(bus.SUM), 32'd2);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_state", 32'(bus.DBG_STATE), 32'(IDLE));
        chk("rst_lfsr", 32'(bus.DBG_LFSR), 32'h00DA);
        @(negedge clk);
        chk("lfsr_step1", 32'(bus.DBG_LFSR), 32'h006D);
        @(negedge clk);
        chk("lfsr_step2", 32'(bus.DBG_LFSR), 32'hB436);
        exp_val[0] = 1;
        exp_val[1] = 1;

        // updates at edges 2, 5, 9; DONE after edge 9
        run_roll(4'd6, 2'b00, -1, 9, 32'h0000_0224, "roll6");
        // die 1 held, die 0 re-rolled
        run_roll(4'd8, 2'b10, -1, 9, 32'h0000_0224, "hold");
        // restart at edge 4: updates 6, 9, 13
        run_roll(4'd6, 2'b00, 4, 13, 32'h0000_2244, "restart");
        // ROLL on the final update edge: no DONE there, updates 11, 14, 18
        run_roll(4'd5, 2'b00, 9, 18, 32'h0004_4824, "lastedge");

        range_rolls(4'd0, 2, "clamp_lo");
        range_rolls(4'd15, 8, "clamp_hi");

        // reset in mid-roll
        bus.ROLL  = 1'b1;
        bus.SIDES = 4'd6;
        @(negedge clk);
        bus.ROLL = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_leds", 32'(bus.LEDS), 32'h8686);
        chk("mid_rst_sum", 32'(bus.SUM), 32'd2);
        chk("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        chk("mid_rst_done", 32'(bus.DONE), 32'd0);
        chk("mid_rst_state", 32'(bus.DBG_STATE), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_lfsr", 32'(bus.DBG_LFSR), 32'h00DA);
        done_seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            done_seen = done_seen | bus.DONE;
            if (c < 4) chk($sformatf("lfsr_model_%0d", c), 32'(bus.DBG_LFSR), 32'(m_lfsr));
        end
        chk("mid_rst_no_done", 32'(done_seen), 32'd0);
        chk("lfsr_model_end", 32'(bus.DBG_LFSR), 32'(m_lfsr));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
